instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder: packs per-field instruction inputs into 32-bit words and streams them into instruction memory at consecutive addresses.
- Sits between the testbench/boot host and the instruction memory write port; loads a program before the processor is released from reset.
- Valid/ready input handshake, registered one-cycle-latency memory write, load-sequencing FSM.

---
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs R/I/J field bundles into 32-bit words and
// streams them into instruction memory. Optional checksum: ENC_CHECKSUM_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_func,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_label,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              busy,
  output logic              done,
  output logic              err_fmt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       enc;
  logic              accept;
  logic              legal;
  logic              wr_beat;
  logic              go;

  assign in_ready = (state_q == S_LOAD) && (cnt_q < num_q);
  assign accept   = in_valid && in_ready;
  assign legal    = (in_fmt != 2'b11);
  assign wr_beat  = accept && legal;
  assign cnt_inc  = cnt_q + 1'b1;
  assign go       = start && (state_q != S_LOAD);

  // Field packing; reserved format encodes to zero and is never written.
  always_comb begin
    enc = '0;
    unique case (in_fmt)
      2'b00: enc = {in_opcode, in_rs, in_rt, in_shamt, 6'b0, in_func};
      2'b01: enc = {in_opcode, in_rs, in_rt, in_imm};
      2'b10: enc = {in_opcode, in_label};
      default: enc = '0;
    endcase
  end

  // Load-sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only honoured outside LOAD; last legal accept ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (num_instr == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (wr_beat && (cnt_inc == num_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Session bookkeeping and the registered one-cycle memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (go) begin
        ptr_q <= base_addr;
        num_q <= num_instr;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= enc;
          ptr_q   <= ptr_q + 1'b1;
          cnt_q   <= cnt_inc;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every word presented on the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    csum_q <= '0;
    else if (go)   csum_q <= '0;
    else if (we_q) csum_q <= csum_q ^ wdata_q;
  end

  assign checksum = csum_q;
`endif

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign err_fmt   = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed vectors, scoreboard queue of expected
// memory writes checked by an independent negedge monitor.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_instr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_shamt, in_func;
  logic [15:0] in_imm;
  logic [25:0] in_label;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err_fmt;
`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;
  logic [41:0] sb[$];

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .num_instr(num_instr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_func(in_func), .in_imm(in_imm),
    .in_label(in_label), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
`ifdef ENC_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy), .done(done), .err_fmt(err_fmt)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got %h@%h expected none",
                   mem_wdata, mem_addr);
        end else begin
          logic [41:0] e;
          e = sb.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            failures++;
            $display("FAIL write: got %h@%h expected %h@%h",
                     mem_wdata, mem_addr, e[31:0], e[41:32]);
          end
        end
      end
    end
  end

  task automatic do_start(logic [9:0] b, logic [10:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_instr = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one bundle, wait (bounded) for in_ready, log expected write.
  task automatic send(logic [1:0] f, logic [5:0] op, logic [4:0] rs,
                      logic [4:0] rt, logic [4:0] sh, logic [4:0] fn,
                      logic [15:0] imm, logic [25:0] lab,
                      logic [9:0] ea, logic [31:0] ed);
    int n;
    in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_func = fn; in_imm = imm; in_label = lab;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got %b expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      if (f != 2'b11) sb.push_back({ea, ed});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic prog3(bit gaps);
    send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0,
         10'h010, 32'h00221804);
    if (gaps) begin
      idle(2);
      send(2'b11, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0,
           10'h0, 32'h0);
      idle(1);
    end
    send(2'b01, 6'd5, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'h0,
         10'h011, 32'h1464FFFF);
    if (gaps) idle(3);
    send(2'b10, 6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000ABC,
         10'h012, 32'h80000ABC);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_instr = '0;
    in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rs = '0;
    in_rt = '0; in_shamt = '0; in_func = '0; in_imm = '0; in_label = '0;
    idle(2);
    chk("rst_outputs",
        {26'b0, in_ready, mem_we, busy, done, err_fmt, |mem_addr},
        32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_ready", {31'b0, in_ready}, 32'h0);

    do_start(10'h010, 11'd3);
    chk("load_busy", {30'b0, busy, in_ready}, 32'h3);
    prog3(1'b0);
    chk("done_after_last", {30'b0, done, in_ready}, 32'h2);
    idle(1);
`ifdef ENC_CHECKSUM_EN
    chk("checksum", checksum, 32'h9446ED47);
`endif
    chk("no_err", {31'b0, err_fmt}, 32'h0);

    do_start(10'h010, 11'd3);
    prog3(1'b1);
    chk("gap_done", {31'b0, done}, 32'h1);
    idle(1);
    chk("err_fmt_set", {31'b0, err_fmt}, 32'h1);

    do_start(10'h020, 11'd1);
    chk("restart_clear", {29'b0, done, err_fmt, busy}, 32'h1);
    send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF,
         10'h020, 32'h0BFFFFFF);
    chk("single_done", {31'b0, done}, 32'h1);
    idle(1);

    do_start(10'h3FF, 11'd2);
    send(2'b01, 6'h23, 5'd31, 5'd1, 5'd0, 5'd0, 16'h8000, 26'h0,
         10'h3FF, 32'h8FE18000);
    send(2'b00, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'h0, 26'h0,
         10'h000, 32'hFFFFF81F);
    idle(1);

    do_start(10'h155, 11'd0);
    chk("num0_done", {30'b0, done, busy}, 32'h2);
    idle(3);

    do_start(10'h040, 11'd2);
    send(2'b01, 6'd1, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0042, 26'h0,
         10'h040, 32'h04430042);
    @(negedge clk);
    start = 1'b1; base_addr = 10'h080; num_instr = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_load", {30'b0, busy, in_ready}, 32'h3);
    send(2'b01, 6'd1, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0043, 26'h0,
         10'h041, 32'h04430043);
    chk("ignored_done", {31'b0, done}, 32'h1);
    idle(1);

    do_start(10'h100, 11'd5);
    send(2'b10, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1,
         10'h100, 32'h04000001);
    send(2'b10, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2,
         10'h101, 32'h04000002);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_load",
        {26'b0, in_ready, mem_we, busy, done, err_fmt, |mem_addr},
        32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("post_rst_idle", {30'b0, busy, in_ready}, 32'h0);

    chk("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
